// File: rtl/pin_update_pkg.sv
// pin_update_pkg: shared FSM states, error codes and PIN normalisation for the PIN-update controller
package pin_update_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_FIRST, S_WAIT_CONFIRM, S_COMMIT, S_DONE} state_e;
  localparam logic [1:0] ERR_BAD_PIN  = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_BAD_SLOT = 2'd3;
  localparam logic [3:0] BLANK_DIGIT  = 4'hE;
  localparam int MAX_DIGITS = 16;
  localparam int MAX_PIN_W  = MAX_DIGITS * 4;
  typedef struct packed {
    logic [MAX_PIN_W-1:0] pin;
    logic                 bad;
    logic                 short_pin;
  } norm_t;
  function automatic norm_t normalise_pin(input logic [MAX_PIN_W-1:0] raw, input int num_digits,
                                          input int min_digits);
    norm_t r;
    int cnt;
    logic [3:0] d;
    r = '0;
    cnt = 0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      d = raw[i*4 +: 4];
      if (i < num_digits && d != BLANK_DIGIT) begin
        r.pin[i*4 +: 4] = d;
        r.bad = r.bad | (d > 4'h9);
        cnt++;
      end
    end
    r.short_pin = cnt < min_digits;
    return r;
  endfunction
endpackage

// File: rtl/pin_table_regs.sv
// pin_table_regs: PIN table storage with a single write port and per-slot programmed flags
module pin_table_regs #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_W     = 2,
  parameter logic [NUM_DIGITS*4-1:0] DEFAULT_MASTER = 16'h1234
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_i,
  input  logic [SLOT_W-1:0]              waddr_i,
  input  logic [NUM_DIGITS*4-1:0]        wdata_i,
  output logic [NUM_SLOTS*NUM_DIGITS*4-1:0] pin_table_o,
  output logic [NUM_SLOTS-1:0]           slot_valid_o
);
  localparam int PW    = NUM_DIGITS * 4;
  localparam int TBL_W = NUM_SLOTS * PW;
  always_ff @(posedge clk) begin
    if (rst) begin
      pin_table_o  <= TBL_W'(DEFAULT_MASTER);
      slot_valid_o <= NUM_SLOTS'(1);
    end else if (we_i) begin
      pin_table_o[waddr_i*PW +: PW] <= wdata_i;
      slot_valid_o[waddr_i]         <= 1'b1;
    end
  end
endmodule

// File: rtl/pin_update_ctrl.sv
// pin_update_ctrl: session FSM that validates, optionally confirms and commits a new PIN into a slot
module pin_update_ctrl
  import pin_update_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int NUM_SLOTS       = 4,
  parameter int MIN_DIGITS      = 4,
  parameter int REQUIRE_CONFIRM = 1,
  parameter int TIMEOUT_CYCLES  = 50_000_000,
  parameter logic [NUM_DIGITS*4-1:0] DEFAULT_MASTER = 16'h1234,
  localparam int SLOT_W = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [SLOT_W-1:0]                 slot_sel,
  input  logic                              pin_valid,
  input  logic [NUM_DIGITS*4-1:0]           pin_digits,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [1:0]                        err_code,
  output logic [NUM_SLOTS*NUM_DIGITS*4-1:0] pin_table,
  output logic [NUM_SLOTS-1:0]              slot_valid
);
  localparam int PW = NUM_DIGITS * 4;
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  state_e            state_q;
  logic [SLOT_W-1:0] slot_q;
  logic [PW-1:0]     shadow_q;
  logic [TW-1:0]     timer_q;
  norm_t             nrm;
  logic [PW-1:0]     pin_n;
  logic              unused_norm;
  logic              bad_pin;
  logic              tmo;
  logic              we;
  assign nrm         = normalise_pin(MAX_PIN_W'(pin_digits), NUM_DIGITS, MIN_DIGITS);
  assign pin_n       = nrm.pin[PW-1:0];
  assign unused_norm = ^nrm.pin;
  assign bad_pin     = nrm.bad | nrm.short_pin;
  assign tmo         = TIMEOUT_CYCLES != 0 && timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign we          = state_q == S_COMMIT && enable;
  assign busy        = state_q inside {S_WAIT_FIRST, S_WAIT_CONFIRM, S_COMMIT};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      slot_q   <= '0;
      shadow_q <= '0;
      timer_q  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_BAD_PIN;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state_q)
        S_IDLE: if (enable) begin
          slot_q  <= slot_sel;
          timer_q <= '0;
          if (32'(slot_sel) >= NUM_SLOTS) begin
            error    <= 1'b1;
            err_code <= ERR_BAD_SLOT;
            state_q  <= S_DONE;
          end else state_q <= S_WAIT_FIRST;
        end
        S_WAIT_FIRST, S_WAIT_CONFIRM:
          if (!enable) state_q <= S_IDLE;
          else if (pin_valid) begin
            timer_q <= '0;
            if (bad_pin) begin
              error    <= 1'b1;
              err_code <= ERR_BAD_PIN;
              shadow_q <= '0;
              state_q  <= S_WAIT_FIRST;
            end else if (state_q == S_WAIT_FIRST) begin
              shadow_q <= pin_n;
              state_q  <= REQUIRE_CONFIRM != 0 ? S_WAIT_CONFIRM : S_COMMIT;
            end else if (pin_n == shadow_q) state_q <= S_COMMIT;
            else begin
              error    <= 1'b1;
              err_code <= ERR_MISMATCH;
              shadow_q <= '0;
              state_q  <= S_WAIT_FIRST;
            end
          end else if (tmo) begin
            error    <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state_q  <= S_DONE;
          end else timer_q <= timer_q + 1'b1;
        S_COMMIT: begin
          done    <= enable;
          state_q <= enable ? S_DONE : S_IDLE;
        end
        S_DONE: if (!enable) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end
  pin_table_regs #(
    .NUM_DIGITS(NUM_DIGITS),
    .NUM_SLOTS(NUM_SLOTS),
    .SLOT_W(SLOT_W),
    .DEFAULT_MASTER(DEFAULT_MASTER)
  ) u_regs (
    .clk(clk),
    .rst(rst),
    .we_i(we),
    .waddr_i(slot_q),
    .wdata_i(shadow_q),
    .pin_table_o(pin_table),
    .slot_valid_o(slot_valid)
  );
endmodule
